// File: rtl/uno_seq.sv
// uno_seq: sequencer driving a shared MAC PE for MAC, div, exp and log ops.
// Define UNO_SEQ_PERF_CNT_EN to add the perf_ops completed-response counter.
`ifndef MAC_BW
`define MAC_BW 12
`endif

module uno_seq #(
    parameter int POLY_DEG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [`MAC_BW-1:0]      req_x,
    input  logic [`MAC_BW-1:0]      req_y,
    input  logic [2*`MAC_BW-1:0]    req_z,
    input  logic                    req_acc,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_op,
    input  logic [1:0]              cfg_idx,
    input  logic [`MAC_BW-1:0]      cfg_data,
    output logic [1:0]              uno_op,
    output logic [`MAC_BW-1:0]      uno_x,
    output logic [`MAC_BW-1:0]      uno_y,
    output logic [`MAC_BW-1:0]      uno_coeff,
    output logic [2*`MAC_BW-1:0]    uno_z,
    output logic                    uno_first_cycle,
    output logic                    uno_last_cycle,
    output logic                    uno_acc_en,
    input  logic [2*`MAC_BW+3:0]    uno_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*`MAC_BW+3:0]    rsp_data
`ifdef UNO_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]             perf_ops
`endif
);

    localparam int BW = `MAC_BW;
    localparam int RW = 2 * BW + 4;
    localparam logic [2:0] LAST_STEP = 3'(POLY_DEG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [1:0]        op_q, op_d;
    logic [BW-1:0]     x_q, x_d;
    logic [BW-1:0]     y_q, y_d;
    logic [2*BW-1:0]   z_q, z_d;
    logic              acc_q, acc_d;
    logic [RW-1:0]     rsp_data_q, rsp_data_d;
    logic [BW-1:0]     tbl_q [1:3][0:3];
    logic [BW-1:0]     tbl_d [1:3][0:3];
`ifdef UNO_SEQ_PERF_CNT_EN
    logic [31:0]       perf_q, perf_d;
`endif

    // Next-state, operand latching, result capture and table writes.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        acc_d      = acc_q;
        rsp_data_d = rsp_data_q;
        tbl_d      = tbl_q;
`ifdef UNO_SEQ_PERF_CNT_EN
        perf_d     = perf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_ISSUE;
                    step_d  = 3'd0;
                    op_d    = req_op;
                    x_d     = req_x;
                    y_d     = req_y;
                    z_d     = req_z;
                    acc_d   = req_acc;
                end
                // Op 00 has no table; other states drop writes.
                if (cfg_we && cfg_op != 2'b00) begin
                    tbl_d[cfg_op][cfg_idx] = cfg_data;
                end
            end
            S_ISSUE: begin
                if (op_q == 2'b00 || step_q == LAST_STEP) begin
                    state_d = S_WAIT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_WAIT: begin
                rsp_data_d = uno_res;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
`ifdef UNO_SEQ_PERF_CNT_EN
                    perf_d  = perf_q + 32'd1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PE operand drive: only active in ISSUE, zero elsewhere.
    always_comb begin
        uno_op          = 2'b00;
        uno_x           = '0;
        uno_y           = '0;
        uno_z           = '0;
        uno_coeff       = '0;
        uno_first_cycle = 1'b0;
        uno_last_cycle  = 1'b0;
        uno_acc_en      = 1'b0;
        if (state_q == S_ISSUE) begin
            uno_op = op_q;
            uno_x  = x_q;
            uno_y  = y_q;
            if (op_q == 2'b00) begin
                uno_z      = z_q;
                uno_acc_en = acc_q;
            end else begin
                uno_first_cycle = (step_q == 3'd0);
                uno_last_cycle  = (step_q == LAST_STEP);
                if (step_q != LAST_STEP) begin
                    uno_coeff = tbl_q[op_q][step_q[1:0]];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
`ifdef UNO_SEQ_PERF_CNT_EN
    assign perf_ops  = perf_q;
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= 3'd0;
            op_q       <= 2'b00;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            acc_q      <= 1'b0;
            rsp_data_q <= '0;
            for (int o = 1; o <= 3; o++) begin
                for (int i = 0; i < 4; i++) begin
                    tbl_q[o][i] <= '0;
                end
            end
`ifdef UNO_SEQ_PERF_CNT_EN
            perf_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            op_q       <= op_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            acc_q      <= acc_d;
            rsp_data_q <= rsp_data_d;
            tbl_q      <= tbl_d;
`ifdef UNO_SEQ_PERF_CNT_EN
            perf_q     <= perf_d;
`endif
        end
    end

endmodule

// File: tb/tb_uno_seq.sv
// tb_uno_seq: scoreboard bench for uno_seq with a behavioural PE stub.
// Define UNO_SEQ_PERF_CNT_EN to also check perf_ops.
`ifndef MAC_BW
`define MAC_BW 12
`endif

module tb_uno_seq;

    localparam int P  = 4;
    localparam int BW = `MAC_BW;
    localparam int RW = 2 * BW + 4;
    localparam longint MASK = (longint'(1) << RW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_acc;
    logic [1:0]        req_op;
    logic [BW-1:0]     req_x, req_y;
    logic [2*BW-1:0]   req_z;
    logic              cfg_we;
    logic [1:0]        cfg_op, cfg_idx;
    logic [BW-1:0]     cfg_data;
    logic [1:0]        uno_op;
    logic [BW-1:0]     uno_x, uno_y, uno_coeff;
    logic [2*BW-1:0]   uno_z;
    logic              uno_first_cycle, uno_last_cycle, uno_acc_en;
    logic [RW-1:0]     uno_res = '0;
    logic              rsp_valid, rsp_ready;
    logic [RW-1:0]     rsp_data;
`ifdef UNO_SEQ_PERF_CNT_EN
    logic [31:0]       perf_ops;
`endif

    uno_seq #(.POLY_DEG(P)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_acc(req_acc),
        .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data),
        .uno_op(uno_op), .uno_x(uno_x), .uno_y(uno_y),
        .uno_coeff(uno_coeff), .uno_z(uno_z),
        .uno_first_cycle(uno_first_cycle),
        .uno_last_cycle(uno_last_cycle), .uno_acc_en(uno_acc_en),
        .uno_res(uno_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data)
`ifdef UNO_SEQ_PERF_CNT_EN
        , .perf_ops(perf_ops)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PE stub: A*B+C for MAC, Horner step h*x+coeff for polynomial ops.
    always @(posedge clk) begin
        if (uno_op == 2'b00) begin
            if (uno_x != '0 || uno_acc_en)
                uno_res <= RW'(uno_x) * RW'(uno_y) + RW'(uno_z)
                         + (uno_acc_en ? uno_res : '0);
        end else begin
            uno_res <= (uno_first_cycle ? '0 : uno_res) * RW'(uno_x)
                     + RW'(uno_coeff);
        end
    end

    typedef struct {
        longint data;
        int     acc_cyc;
        int     lat;
    } exp_t;

    typedef struct {
        logic [BW-1:0] c;
        logic [BW-1:0] x;
        logic          f;
        logic          l;
    } stp_t;

    exp_t          exp_q[$];
    stp_t          stp_q[$];
    logic [BW-1:0] mtbl[1:3][0:3];
    longint        last_res = 0;
    bit            last_ok = 1'b0;
    int            mac_issued = 0, mac_seen = 0, done_cnt = 0;
    int            rdy_mode = 0;
    int            checks = 0, fails = 0;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endfunction

    // Response-side ready: random, held low, or held high.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: rsp_ready = 1'b0;
                2: rsp_ready = 1'b1;
                default: rsp_ready = ($urandom % 3) != 0;
            endcase
        end
    end

    // Step monitor: checks every PE step against the expected stream.
    always @(negedge clk) begin
        stp_t s;
        if (uno_op != 2'b00) begin
            if (stp_q.size() == 0) begin
                chk("unexpected_step", 1, 0);
            end else begin
                s = stp_q.pop_front();
                chk("step_coeff", uno_coeff, s.c);
                chk("step_first", uno_first_cycle, s.f);
                chk("step_last", uno_last_cycle, s.l);
                chk("step_x_hold", uno_x, s.x);
                chk("step_acc_en", uno_acc_en, 0);
            end
        end else if (uno_x != '0 || uno_acc_en) begin
            mac_seen++;
            chk("mac_step_ctl",
                {uno_first_cycle, uno_last_cycle, |uno_coeff}, 0);
        end
        if (req_ready || rsp_valid) begin
            chk("uno_quiet",
                {|uno_op, |uno_x, |uno_y, |uno_z, |uno_coeff,
                 uno_first_cycle, uno_last_cycle, uno_acc_en}, 0);
        end
    end

    // Response monitor: pops the scoreboard on each new response.
    bit   seen = 1'b0;
    bit   hs_prev = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (hs_prev) begin
            chk("post_hs_rsp_valid", rsp_valid, 0);
            chk("post_hs_req_ready", req_ready, 1);
            hs_prev = 1'b0;
        end
        if (rsp_valid) begin
            chk("resp_req_ready", req_ready, 0);
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                    cur.data = -1;
                    cur.lat = 0;
                    cur.acc_cyc = cyc;
                end else begin
                    cur = exp_q.pop_front();
                    chk("rsp_latency", cyc - cur.acc_cyc, cur.lat);
                end
                seen = 1'b1;
            end
            chk("rsp_data", rsp_data, cur.data);
            if (rsp_ready) begin
                seen = 1'b0;
                hs_prev = 1'b1;
                done_cnt++;
            end
        end
    end

    task automatic do_req(input logic [1:0] op, input logic [BW-1:0] x,
                          input logic [BW-1:0] y, input logic [2*BW-1:0] z,
                          input logic acc);
        int     n = 0;
        exp_t   e;
        stp_t   s;
        longint h;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_x = x;
        req_y = y;
        req_z = z;
        req_acc = acc;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (op == 2'b00) begin
            h = longint'(x) * longint'(y) + longint'(z)
              + (acc ? last_res : 0);
            e.lat = 2;
            mac_issued++;
        end else begin
            h = 0;
            for (int k = 0; k <= P; k++) begin
                s.c = (k < P) ? mtbl[op][k] : '0;
                s.x = x;
                s.f = (k == 0);
                s.l = (k == P);
                stp_q.push_back(s);
                h = (h * longint'(x) + longint'(s.c)) & MASK;
            end
            e.lat = P + 2;
        end
        h = h & MASK;
        last_res = h;
        last_ok = 1'b1;
        e.data = h;
        e.acc_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_x = BW'($urandom);
        req_y = BW'($urandom);
        req_z = (2*BW)'($urandom);
        req_acc = 1'($urandom);
    endtask

    task automatic cfg_write(input logic [1:0] op, input logic [1:0] idx,
                             input logic [BW-1:0] data, input bit upd);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_op = op;
        cfg_idx = idx;
        cfg_data = data;
        if (upd && op != 2'b00) mtbl[op][idx] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", req_ready, 1);
    endtask

    task automatic clear_model();
        for (int o = 1; o <= 3; o++)
            for (int i = 0; i < 4; i++)
                mtbl[o][i] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    op;
        logic [BW-1:0] x;
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_x = '0;
        req_y = '0;
        req_z = '0;
        req_acc = 1'b0;
        cfg_we = 1'b0;
        cfg_op = '0;
        cfg_idx = '0;
        cfg_data = '0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);

        // Directed MAC 3*5+7.
        do_req(2'b00, 3, 5, 7, 1'b0);
        chk("mac_model_22", last_res, 22);
        wait_idle();

        // Exp with table {1,2,3,4}.
        for (int i = 0; i < 4; i++) cfg_write(2'b10, 2'(i), BW'(i + 1), 1);
        do_req(2'b10, 12'd2, 12'd9, '0, 1'b0);
        wait_idle();

        // Response held off for 10+ cycles, then released.
        rdy_mode = 1;
        do_req(2'b00, 12'd100, 12'd200, 24'd300, 1'b1);
        repeat (13) @(negedge clk);
        chk("stall_rsp_valid", rsp_valid, 1);
        rdy_mode = 2;
        wait_idle();
        rdy_mode = 0;

        // Table write during a busy div is dropped.
        do_req(2'b01, 12'd7, 12'd1, '0, 1'b0);
        cfg_write(2'b11, 2'd2, 12'hABC, 0);
        wait_idle();
        do_req(2'b11, 12'd3, 12'd0, '0, 1'b0);
        wait_idle();
        cfg_write(2'b11, 2'd2, 12'hABC, 1);
        do_req(2'b11, 12'd3, 12'd0, '0, 1'b0);
        wait_idle();

        // Reset during step 2 of a log op abandons it.
        do_req(2'b11, 12'd5, 12'd0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_back());
        stp_q.delete();
        clear_model();
        last_ok = 1'b0;
        done_cnt = 0;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_data", rsp_data, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_rsp", rsp_valid, 0);

        // Table was cleared by reset.
        do_req(2'b11, 12'd9, 12'd0, '0, 1'b0);
        wait_idle();

        // Randomized mix of ops and table writes.
        for (int it = 0; it < 40; it++) begin
            if ($urandom % 3 == 0) begin
                wait_idle();
                cfg_write(2'($urandom), 2'($urandom), BW'($urandom), 1);
            end
            op = 2'($urandom);
            x = BW'($urandom_range(1, (1 << BW) - 1));
            do_req(op, x, BW'($urandom), (2*BW)'($urandom),
                   last_ok ? 1'($urandom) : 1'b0);
            if ($urandom % 4 == 0)
                cfg_write(2'($urandom_range(1, 3)), 2'($urandom),
                          BW'($urandom), 0);
        end

        wait_idle();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("steps_consumed", stp_q.size(), 0);
        chk("mac_step_count", mac_seen, mac_issued);
`ifdef UNO_SEQ_PERF_CNT_EN
        chk("perf_ops", perf_ops, done_cnt);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/uno_seq.md
UNO_SEQ -- requirements
Module: uno_seq

Interface
REQ-001 SHALL have parameter POLY_DEG, default 4, range 1..4: Horner coefficient steps per div/exp/log operation.
REQ-002 SHALL take datapath width MAC_BW from the `MAC_BW macro in param_def.sv (12); RW = 2*MAC_BW+4.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have req_valid/req_ready (in/out, 1 each): request handshake.
REQ-006 SHALL have req_op (in, 2): 00 MAC, 01 div, 10 exp, 11 log.
REQ-007 SHALL have req_x, req_y (in, MAC_BW), req_z (in, 2*MAC_BW) and req_acc (in, 1, MAC accumulate).
REQ-008 SHALL have cfg_we (in, 1), cfg_op (in, 2), cfg_idx (in, 2) and cfg_data (in, MAC_BW): coefficient table write port.
REQ-009 SHALL have uno_op (out, 2), uno_x/uno_y/uno_coeff (out, MAC_BW) and uno_z (out, 2*MAC_BW): PE operand drive.
REQ-010 SHALL have uno_first_cycle, uno_last_cycle, uno_acc_en (out, 1 each): PE step control.
REQ-011 SHALL have uno_res (in, RW): registered PE MAC output, valid one cycle after the step issuing it.
REQ-012 SHALL have rsp_valid/rsp_ready (out/in, 1) and rsp_data (out, RW): result handshake.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready at a rising edge, and op/x/y/z/acc are latched then.
REQ-015 ISSUE, MAC op: one step driving uno_x=x, uno_y=y, uno_z=z, uno_acc_en=acc, first/last=0, coeff=0.
REQ-016 ISSUE, nonlinear op: steps k=0..POLY_DEG; coeff=table[op][k] for k<POLY_DEG and 0 at k=POLY_DEG.
REQ-017 Nonlinear op: first_cycle=1 only at step 0; last_cycle=1 only at step POLY_DEG; acc_en=0; uno_x/uno_y held at the latched values for all steps.
REQ-018 WAIT: one cycle, all uno_* controls 0; rsp_data <= uno_res at the end of WAIT.
REQ-019 SHALL raise rsp_valid 2 edges after acceptance for MAC and POLY_DEG+2 edges after for nonlinear ops.
REQ-020 RESP: rsp_valid and rsp_data SHALL hold stable until rsp_valid&&rsp_ready; leave to IDLE on that edge.
REQ-021 Back-to-back: no new request in the cycle of rsp handshake; req_ready rises the cycle after.
REQ-022 SHALL drive all uno_* outputs to 0 in IDLE, RESP and WAIT; uno_op SHALL equal the latched op in ISSUE.
REQ-023 Coefficient table: 3x4 entries (op 01..11, idx 0..3); writes SHALL apply only in IDLE, otherwise dropped silently.
REQ-024 Writes with cfg_op=00 SHALL be ignored; read of a table entry in the same cycle as its write SHALL return the old value.

Reset
REQ-025 rst SHALL return the FSM to IDLE from any state, abandoning any in-flight operation with no response.
REQ-026 On rst: rsp_valid=0, rsp_data=0, all uno_* outputs 0, latched operands 0, table entries 0, and req_ready=1 from the first cycle after reset.

Configuration
REQ-027 With UNO_SEQ_PERF_CNT_EN defined, SHALL add output perf_ops (32): responses completed; it resets to 0 and wraps at 2^32.
REQ-028 Without UNO_SEQ_PERF_CNT_EN, the perf_ops port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 MAC x=3, y=5, z=7, acc=0, PE stub A*B+C -> one step seen, rsp_valid at edge +2, rsp_data=22.
REQ-030 Table exp={1,2,3,4}, POLY_DEG=4, exp request -> coeff 1,2,3,4,0 on 5 consecutive cycles; first at step 0, last at step 4; rsp_valid at edge +6.
REQ-031 rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout; completes on the first ready.
REQ-032 cfg write to log idx 2 during a busy div -> table unchanged; the same write issued in IDLE then takes effect.
REQ-033 rst asserted at step 2 of a log operation -> next cycle IDLE, rsp_valid=0, and no response ever appears for that request.
REQ-034 With UNO_SEQ_PERF_CNT_EN: 3 completed ops plus 1 reset-aborted op -> perf_ops=3 (or 0 if counted after that reset).
